// File: rtl/hyper_reg_pkg.sv
// hyper_reg_pkg
// Shared constants for the HyperBus register interface: register word
// offsets, descriptor mode codes, bit positions inside CFG/STATUS/CLK_DIV
// words and the clock-divider handshake state encoding.
package hyper_reg_pkg;

    localparam logic [4:0] ADDR_RX_SADDR     = 5'd0;
    localparam logic [4:0] ADDR_RX_SIZE      = 5'd1;
    localparam logic [4:0] ADDR_RX_CFG       = 5'd2;
    localparam logic [4:0] ADDR_TX_SADDR     = 5'd3;
    localparam logic [4:0] ADDR_TX_SIZE      = 5'd4;
    localparam logic [4:0] ADDR_TX_CFG       = 5'd5;
    localparam logic [4:0] ADDR_EXT_ADDR     = 5'd6;
    localparam logic [4:0] ADDR_EXT_CFG      = 5'd7;
    localparam logic [4:0] ADDR_TRANS_CTRL   = 5'd8;
    localparam logic [4:0] ADDR_CLK_DIV      = 5'd9;
    localparam logic [4:0] ADDR_REG_VAL      = 5'd10;
    localparam logic [4:0] ADDR_STATUS       = 5'd11;
    localparam logic [4:0] ADDR_MEM_CFG_BASE = 5'd16;

    localparam logic [3:0] MODE_NORMAL = 4'd0;
    localparam logic [3:0] MODE_REG    = 4'd1;
    localparam logic [3:0] MODE_2D     = 4'd2;

    localparam int CFG_CONT_BIT     = 0;
    localparam int CFG_EN_BIT       = 4;
    localparam int CFG_CLR_BIT      = 5;
    localparam int TRANS_PUSH_BIT   = 0;
    localparam int TRANS_RXN_BIT    = 1;
    localparam int CLK_DIV_BUSY_BIT = 8;
    localparam int CLK_DIV_EN_BIT   = 31;
    localparam int REG_VAL_RXN_BIT  = 16;
    localparam int STAT_Q_OVF_BIT   = 8;
    localparam int STAT_ARG_OVF_BIT = 9;

    typedef enum logic [1:0] {
        CD_IDLE   = 2'd0,
        CD_REQ    = 2'd1,
        CD_ACKGAP = 2'd2
    } clk_div_state_e;

endpackage

// File: rtl/hyper_trans_queue.sv
// hyper_trans_queue
// First-word-fall-through descriptor FIFO.
// Ports: push_i/data_i write side, pop_i read request (qualified internally
// with not-empty), data_o head entry, valid_o not empty, full_o,
// level_o occupancy, push_drop_o pulses when a push is refused.
module hyper_trans_queue #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o,
    output logic             push_drop_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             pop_ok, push_ok;

    always_comb begin
        pop_ok  = pop_i & (level_q != '0);
        // A full queue still takes a push when the head leaves in the same cycle.
        push_ok = push_i & ((level_q != LVL_W'(DEPTH)) | pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign data_o      = mem_q[rd_ptr_q];
    assign valid_o     = (level_q != '0);
    assign full_o      = (level_q == LVL_W'(DEPTH));
    assign level_o     = level_q;
    assign push_drop_o = push_i & ~push_ok;

endmodule

// File: rtl/hyper_reg_if_mc.sv
// hyper_reg_if_mc
// Register interface for the uDMA HyperRAM/FLASH controller.
// Ports: cfg_* register bus (combinational read), RX/TX uDMA channel
// programming and status, per-chip-select memory timing vectors,
// clock-divider request/ack handshake, descriptor FIFO head with
// valid/ready, and a one-deep register-argument slot with valid/ready.
module hyper_reg_if_mc
    import hyper_reg_pkg::*;
#(
    parameter  int L2_AWIDTH_NOAL  = 12,
    parameter  int TRANS_SIZE      = 16,
    parameter  int N_CH            = 2,
    localparam int CH_W            = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter  int QUEUE_DEPTH     = 4,
    localparam int TRANS_DATA_SIZE = 32 + TRANS_SIZE + CH_W + 1 + 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [31:0]                cfg_data_i,
    input  logic [4:0]                 cfg_addr_i,
    input  logic                       cfg_valid_i,
    input  logic                       cfg_rwn_i,
    output logic [31:0]                cfg_data_o,
    output logic                       cfg_ready_o,
    output logic [L2_AWIDTH_NOAL-1:0]  cfg_rx_startaddr_o,
    output logic [TRANS_SIZE-1:0]      cfg_rx_size_o,
    output logic                       cfg_rx_continuous_o,
    output logic                       cfg_rx_en_o,
    output logic                       cfg_rx_clr_o,
    input  logic                       cfg_rx_en_i,
    input  logic                       cfg_rx_pending_i,
    input  logic [L2_AWIDTH_NOAL-1:0]  cfg_rx_curr_addr_i,
    input  logic [TRANS_SIZE-1:0]      cfg_rx_bytes_left_i,
    output logic [L2_AWIDTH_NOAL-1:0]  cfg_tx_startaddr_o,
    output logic [TRANS_SIZE-1:0]      cfg_tx_size_o,
    output logic                       cfg_tx_continuous_o,
    output logic                       cfg_tx_en_o,
    output logic                       cfg_tx_clr_o,
    input  logic                       cfg_tx_en_i,
    input  logic                       cfg_tx_pending_i,
    input  logic [L2_AWIDTH_NOAL-1:0]  cfg_tx_curr_addr_i,
    input  logic [TRANS_SIZE-1:0]      cfg_tx_bytes_left_i,
    output logic [4*N_CH-1:0]          cfg_latency_access_o,
    output logic [4*N_CH-1:0]          cfg_read_write_recovery_o,
    output logic [3*N_CH-1:0]          cfg_rwds_delay_line_o,
    output logic [2*N_CH-1:0]          cfg_variable_latency_check_o,
    output logic [N_CH-1:0]            cfg_en_latency_additional_o,
    output logic [16*N_CH-1:0]         cfg_cs_max_o,
    output logic                       clk_div_enable_o,
    output logic [7:0]                 clk_div_data_o,
    output logic                       clk_div_valid_o,
    input  logic                       clk_div_ack_i,
    output logic [TRANS_DATA_SIZE-1:0] cfg_trans_data_o,
    output logic                       cfg_trans_valid_o,
    input  logic                       cfg_trans_ready_i,
    output logic [31:0]                cfg_arg_data_o,
    output logic                       cfg_arg_valid_o,
    input  logic                       cfg_arg_ready_i
);

    localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;

    logic [L2_AWIDTH_NOAL-1:0] rx_saddr_q, rx_saddr_d, tx_saddr_q, tx_saddr_d;
    logic [TRANS_SIZE-1:0]     rx_size_q, rx_size_d, tx_size_q, tx_size_d;
    logic                      rx_cont_q, rx_cont_d, tx_cont_q, tx_cont_d;
    logic                      rx_en_q, rx_en_d, tx_en_q, tx_en_d;
    logic                      rx_clr_q, rx_clr_d, tx_clr_q, tx_clr_d;
    logic [31:0]               ext_addr_q, ext_addr_d;
    logic [3:0]                ext_mode_q, ext_mode_d;
    logic [CH_W-1:0]           ext_ch_q, ext_ch_d;
    logic [15:0]               arg_val_q, arg_val_d;
    logic                      arg_rxn_q, arg_rxn_d;
    logic                      arg_valid_q, arg_valid_d;
    logic                      q_ovf_q, q_ovf_d, arg_ovf_q, arg_ovf_d;
    clk_div_state_e            cd_state_q, cd_state_d;
    logic [7:0]                cd_data_q, cd_data_d, cd_shadow_q, cd_shadow_d;
    logic                      cd_pend_q, cd_pend_d;
    logic                      cd_valid_q, cd_valid_d, cd_en_q, cd_en_d;
    logic [3:0]                lat_q [N_CH], lat_d [N_CH], rwr_q [N_CH], rwr_d [N_CH];
    logic [2:0]                rwds_q [N_CH], rwds_d [N_CH];
    logic [1:0]                chk_q [N_CH], chk_d [N_CH];
    logic                      addl_q [N_CH], addl_d [N_CH];
    logic [15:0]               csmax_q [N_CH], csmax_d [N_CH];

    logic                       wr, push, q_drop, cd_busy, wr_cd;
    logic [TRANS_DATA_SIZE-1:0] push_data;
    logic [LVL_W-1:0]           q_level;
    logic                       q_full;

    hyper_trans_queue #(.WIDTH(TRANS_DATA_SIZE), .DEPTH(QUEUE_DEPTH)) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .data_i      (push_data),
        .pop_i       (cfg_trans_ready_i),
        .data_o      (cfg_trans_data_o),
        .valid_o     (cfg_trans_valid_o),
        .full_o      (q_full),
        .level_o     (q_level),
        .push_drop_o (q_drop)
    );

    assign wr      = cfg_valid_i & ~cfg_rwn_i;
    assign wr_cd   = wr & (cfg_addr_i == ADDR_CLK_DIV);
    assign cd_busy = (cd_state_q != CD_IDLE) | cd_pend_q;
    // Descriptor is built from register contents before this write lands.
    assign push    = wr & (cfg_addr_i == ADDR_TRANS_CTRL) & cfg_data_i[TRANS_PUSH_BIT];
    assign push_data = {ext_addr_q,
                        cfg_data_i[TRANS_RXN_BIT] ? rx_size_q : tx_size_q,
                        ext_ch_q, cfg_data_i[TRANS_RXN_BIT], ext_mode_q};

    always_comb begin
        rx_saddr_d = rx_saddr_q;  tx_saddr_d = tx_saddr_q;
        rx_size_d  = rx_size_q;   tx_size_d  = tx_size_q;
        rx_cont_d  = rx_cont_q;   tx_cont_d  = tx_cont_q;
        rx_en_d    = 1'b0;        tx_en_d    = 1'b0;
        rx_clr_d   = 1'b0;        tx_clr_d   = 1'b0;
        ext_addr_d = ext_addr_q;  ext_mode_d = ext_mode_q;
        ext_ch_d   = ext_ch_q;
        arg_val_d  = arg_val_q;   arg_rxn_d  = arg_rxn_q;
        arg_valid_d = arg_valid_q;
        q_ovf_d    = q_ovf_q;     arg_ovf_d  = arg_ovf_q;
        lat_d = lat_q;  rwr_d = rwr_q;  rwds_d = rwds_q;
        chk_d = chk_q;  addl_d = addl_q; csmax_d = csmax_q;

        if (arg_valid_q && cfg_arg_ready_i) begin
            arg_valid_d = 1'b0;
        end

        if (wr) begin
            case (cfg_addr_i)
                ADDR_RX_SADDR: rx_saddr_d = cfg_data_i[L2_AWIDTH_NOAL-1:0];
                ADDR_RX_SIZE:  rx_size_d  = cfg_data_i[TRANS_SIZE-1:0];
                ADDR_RX_CFG: begin
                    rx_cont_d = cfg_data_i[CFG_CONT_BIT];
                    rx_en_d   = cfg_data_i[CFG_EN_BIT];
                    rx_clr_d  = cfg_data_i[CFG_CLR_BIT];
                end
                ADDR_TX_SADDR: tx_saddr_d = cfg_data_i[L2_AWIDTH_NOAL-1:0];
                ADDR_TX_SIZE:  tx_size_d  = cfg_data_i[TRANS_SIZE-1:0];
                ADDR_TX_CFG: begin
                    tx_cont_d = cfg_data_i[CFG_CONT_BIT];
                    tx_en_d   = cfg_data_i[CFG_EN_BIT];
                    tx_clr_d  = cfg_data_i[CFG_CLR_BIT];
                end
                ADDR_EXT_ADDR: ext_addr_d = cfg_data_i;
                ADDR_EXT_CFG: begin
                    ext_mode_d = cfg_data_i[3:0];
                    ext_ch_d   = cfg_data_i[8 +: CH_W];
                end
                ADDR_REG_VAL: begin
                    // A full slot that is not draining this cycle refuses the write.
                    if (arg_valid_q && !cfg_arg_ready_i) begin
                        arg_ovf_d = 1'b1;
                    end else begin
                        arg_val_d   = cfg_data_i[15:0];
                        arg_rxn_d   = cfg_data_i[REG_VAL_RXN_BIT];
                        arg_valid_d = 1'b1;
                    end
                end
                ADDR_STATUS: begin
                    if (cfg_data_i[STAT_Q_OVF_BIT])   q_ovf_d   = 1'b0;
                    if (cfg_data_i[STAT_ARG_OVF_BIT]) arg_ovf_d = 1'b0;
                end
                default: ;
            endcase
            for (int c = 0; c < N_CH; c++) begin
                if (cfg_addr_i == 5'(ADDR_MEM_CFG_BASE + 5'(c))) begin
                    lat_d[c]   = cfg_data_i[3:0];
                    rwr_d[c]   = cfg_data_i[7:4];
                    rwds_d[c]  = cfg_data_i[10:8];
                    chk_d[c]   = cfg_data_i[12:11];
                    addl_d[c]  = cfg_data_i[13];
                    csmax_d[c] = cfg_data_i[31:16];
                end
            end
        end

        // Sticky set after the clear so a coincident set wins.
        if (q_drop) begin
            q_ovf_d = 1'b1;
        end
    end

    // Clock-divider request: a write during an outstanding request is parked
    // in the shadow; on ack the shadow (or a coincident write) is reissued
    // after one cycle with valid low so the consumer sees a fresh request.
    always_comb begin
        cd_state_d  = cd_state_q;
        cd_data_d   = cd_data_q;
        cd_shadow_d = cd_shadow_q;
        cd_pend_d   = cd_pend_q;
        cd_valid_d  = cd_valid_q;
        cd_en_d     = wr_cd ? cfg_data_i[CLK_DIV_EN_BIT] : cd_en_q;
        case (cd_state_q)
            CD_IDLE: begin
                if (wr_cd) begin
                    cd_data_d  = cfg_data_i[7:0];
                    cd_valid_d = 1'b1;
                    cd_state_d = CD_REQ;
                end
            end
            CD_REQ: begin
                if (clk_div_ack_i) begin
                    cd_valid_d = 1'b0;
                    if (wr_cd || cd_pend_q) begin
                        cd_data_d  = wr_cd ? cfg_data_i[7:0] : cd_shadow_q;
                        cd_pend_d  = 1'b0;
                        cd_state_d = CD_ACKGAP;
                    end else begin
                        cd_state_d = CD_IDLE;
                    end
                end else if (wr_cd) begin
                    cd_shadow_d = cfg_data_i[7:0];
                    cd_pend_d   = 1'b1;
                end
            end
            CD_ACKGAP: begin
                if (wr_cd) begin
                    cd_shadow_d = cfg_data_i[7:0];
                    cd_pend_d   = 1'b1;
                end
                cd_valid_d = 1'b1;
                cd_state_d = CD_REQ;
            end
            default: begin
                cd_valid_d = 1'b0;
                cd_state_d = CD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_saddr_q <= '0;  tx_saddr_q <= '0;
            rx_size_q  <= '0;  tx_size_q  <= '0;
            rx_cont_q  <= 1'b0; tx_cont_q <= 1'b0;
            rx_en_q    <= 1'b0; tx_en_q   <= 1'b0;
            rx_clr_q   <= 1'b0; tx_clr_q  <= 1'b0;
            ext_addr_q <= '0;  ext_mode_q <= '0;  ext_ch_q <= '0;
            arg_val_q  <= '0;  arg_rxn_q  <= 1'b0; arg_valid_q <= 1'b0;
            q_ovf_q    <= 1'b0; arg_ovf_q <= 1'b0;
            cd_state_q <= CD_IDLE;
            cd_data_q  <= '0;  cd_shadow_q <= '0;
            cd_pend_q  <= 1'b0; cd_valid_q <= 1'b0; cd_en_q <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                lat_q[c] <= '0;  rwr_q[c] <= '0;  rwds_q[c] <= '0;
                chk_q[c] <= '0;  addl_q[c] <= 1'b0; csmax_q[c] <= '0;
            end
        end else begin
            rx_saddr_q <= rx_saddr_d;  tx_saddr_q <= tx_saddr_d;
            rx_size_q  <= rx_size_d;   tx_size_q  <= tx_size_d;
            rx_cont_q  <= rx_cont_d;   tx_cont_q  <= tx_cont_d;
            rx_en_q    <= rx_en_d;     tx_en_q    <= tx_en_d;
            rx_clr_q   <= rx_clr_d;    tx_clr_q   <= tx_clr_d;
            ext_addr_q <= ext_addr_d;  ext_mode_q <= ext_mode_d;  ext_ch_q <= ext_ch_d;
            arg_val_q  <= arg_val_d;   arg_rxn_q  <= arg_rxn_d;   arg_valid_q <= arg_valid_d;
            q_ovf_q    <= q_ovf_d;     arg_ovf_q  <= arg_ovf_d;
            cd_state_q <= cd_state_d;
            cd_data_q  <= cd_data_d;   cd_shadow_q <= cd_shadow_d;
            cd_pend_q  <= cd_pend_d;   cd_valid_q <= cd_valid_d;  cd_en_q <= cd_en_d;
            lat_q  <= lat_d;   rwr_q  <= rwr_d;   rwds_q  <= rwds_d;
            chk_q  <= chk_d;   addl_q <= addl_d;  csmax_q <= csmax_d;
        end
    end

    always_comb begin
        cfg_data_o = '0;
        case (cfg_addr_i)
            ADDR_RX_SADDR: cfg_data_o[L2_AWIDTH_NOAL-1:0] = cfg_rx_curr_addr_i;
            ADDR_RX_SIZE:  cfg_data_o[TRANS_SIZE-1:0]     = cfg_rx_bytes_left_i;
            ADDR_RX_CFG:   cfg_data_o = {26'h0, cfg_rx_pending_i, cfg_rx_en_i, 3'h0, rx_cont_q};
            ADDR_TX_SADDR: cfg_data_o[L2_AWIDTH_NOAL-1:0] = cfg_tx_curr_addr_i;
            ADDR_TX_SIZE:  cfg_data_o[TRANS_SIZE-1:0]     = cfg_tx_bytes_left_i;
            ADDR_TX_CFG:   cfg_data_o = {26'h0, cfg_tx_pending_i, cfg_tx_en_i, 3'h0, tx_cont_q};
            ADDR_EXT_ADDR: cfg_data_o = ext_addr_q;
            ADDR_EXT_CFG: begin
                cfg_data_o[3:0]      = ext_mode_q;
                cfg_data_o[8 +: CH_W] = ext_ch_q;
            end
            ADDR_CLK_DIV:  cfg_data_o = {cd_en_q, 22'h0, cd_busy, cd_data_q};
            ADDR_REG_VAL:  cfg_data_o = {15'h0, arg_rxn_q, arg_val_q};
            ADDR_STATUS:   cfg_data_o = {22'h0, arg_ovf_q, q_ovf_q, 8'(q_level)};
            default: ;
        endcase
        for (int c = 0; c < N_CH; c++) begin
            if (cfg_addr_i == 5'(ADDR_MEM_CFG_BASE + 5'(c))) begin
                cfg_data_o = {csmax_q[c], 2'b00, addl_q[c], chk_q[c], rwds_q[c], rwr_q[c], lat_q[c]};
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign cfg_latency_access_o[4*c +: 4]         = lat_q[c];
        assign cfg_read_write_recovery_o[4*c +: 4]    = rwr_q[c];
        assign cfg_rwds_delay_line_o[3*c +: 3]        = rwds_q[c];
        assign cfg_variable_latency_check_o[2*c +: 2] = chk_q[c];
        assign cfg_en_latency_additional_o[c]         = addl_q[c];
        assign cfg_cs_max_o[16*c +: 16]               = csmax_q[c];
    end

    assign cfg_ready_o         = 1'b1;
    assign cfg_rx_startaddr_o  = rx_saddr_q;
    assign cfg_rx_size_o       = rx_size_q;
    assign cfg_rx_continuous_o = rx_cont_q;
    assign cfg_rx_en_o         = rx_en_q;
    assign cfg_rx_clr_o        = rx_clr_q;
    assign cfg_tx_startaddr_o  = tx_saddr_q;
    assign cfg_tx_size_o       = tx_size_q;
    assign cfg_tx_continuous_o = tx_cont_q;
    assign cfg_tx_en_o         = tx_en_q;
    assign cfg_tx_clr_o        = tx_clr_q;
    assign clk_div_enable_o    = cd_en_q;
    assign clk_div_data_o      = cd_data_q;
    assign clk_div_valid_o     = cd_valid_q;
    assign cfg_arg_data_o      = {15'h0, arg_rxn_q, arg_val_q};
    assign cfg_arg_valid_o     = arg_valid_q;

endmodule
